mem_port_arbiter: RTL and testbench

Shares the single-port synchronous data/instruction memory between the instruction-fetch requester and the load/store requester, which is driven by the control unit's LdStCtrl/MemWrite decode. Sequences each access through an issue/wait/respond FSM and generates byte-lane write enables. Formats load data with sign or zero extension. Flags misaligned accesses. Sits between the fetch and memory stages and the memory macro.

---
 rtl/mem_port_arbiter_pkg.sv | 37 +++
 rtl/ldst_align.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: load/store opcodes, FSM states,
// byte-lane masks and the latched request record.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100,
    ST_B  = 3'b101,
    ST_H  = 3'b110,
    ST_W  = 3'b111
  } ldst_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef struct packed {
    logic       is_dm;
    ldst_e      ldst;
    logic [1:0] lo;
  } req_t;

  function automatic logic is_store(input ldst_e op);
    return op inside {ST_B, ST_H, ST_W};
  endfunction

endpackage

// File: rtl/ldst_align.sv
// Byte-lane steering for one access: store write enables and lane replication,
// load sign/zero extension, and the misalignment flag.
module ldst_align
  import mem_port_arbiter_pkg::*;
(
  input  ldst_e       ldst,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{a, 3'b000} +: 8];
  assign half_sel = a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    we         = '0;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (ldst)
      LD_B:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: rdata_ext = {24'd0, byte_sel};
      LD_H: begin
        misaligned = a[0];
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
      end
      LD_HU: begin
        misaligned = a[0];
        rdata_ext  = {16'd0, half_sel};
      end
      LD_W:  misaligned = (a != 2'b00);
      ST_B: begin
        we        = LANE_B << a;
        wdata_rep = {4{wdata[7:0]}};
      end
      ST_H: begin
        misaligned = a[0];
        we         = LANE_H << {a[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
      end
      ST_W: begin
        misaligned = (a != 2'b00);
        we         = LANE_W;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store,
// one access in flight at a time, with a fairness cap on consecutive data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int FAIR_MAX = 4,
  parameter int AW       = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ready,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic [31:0]   dm_addr,
  input  logic [2:0]    dm_ldst,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ready,
  output logic          dm_err,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int FW = $clog2(FAIR_MAX + 1);

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [FW-1:0] fair_q, fair_d;
  logic [2:0]    wait_q, wait_d;
  logic          if_ready_q, if_ready_d, dm_ready_q, dm_ready_d, dm_err_q, dm_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          grant_if;

  // The aligner sees the live request while arbitrating and the latched one afterwards.
  ldst_e       al_op;
  logic [1:0]  al_a;
  logic [3:0]  al_we;
  logic [31:0] al_wdata, al_rdata;
  logic        al_mis;

  assign al_op = (state_q == S_IDLE) ? ldst_e'(dm_ldst) : req_q.ldst;
  assign al_a  = (state_q == S_IDLE) ? dm_addr[1:0] : req_q.lo;

  ldst_align u_align (
    .ldst       (al_op),
    .a          (al_a),
    .wdata      (dm_wdata),
    .rdata      (mem_rdata),
    .we         (al_we),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  logic unused_addr;
  assign unused_addr = ^{if_addr[31:AW+2], if_addr[1:0], dm_addr[31:AW+2]};

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    fair_d      = fair_q;
    wait_d      = wait_q;
    grant_if    = 1'b0;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        grant_if = if_req && (!dm_req || fair_q == FW'(FAIR_MAX));
        if (!if_req || grant_if)
          fair_d = '0;
        else if (dm_req && fair_q != FW'(FAIR_MAX))
          fair_d = fair_q + 1'b1;
        if (if_req || dm_req) begin
          req_d = '{is_dm: !grant_if, ldst: ldst_e'(dm_ldst), lo: dm_addr[1:0]};
          if (!grant_if && al_mis) begin
            // Misaligned data access never touches memory.
            state_d    = S_RESP;
            dm_ready_d = 1'b1;
            dm_err_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            state_d    = S_ISSUE;
            mem_en_d   = 1'b1;
            mem_addr_d = grant_if ? if_addr[AW+1:2] : dm_addr[AW+1:2];
            if (!grant_if) begin
              mem_we_d    = al_we;
              mem_wdata_d = al_wdata;
            end
          end
        end
      end
      S_ISSUE: begin
        if (req_q.is_dm && is_store(req_q.ldst)) begin
          state_d    = S_RESP;
          dm_ready_d = 1'b1;
          dm_rdata_d = '0;
        end else begin
          state_d = S_WAIT;
          wait_d  = 3'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = S_RESP;
          if (req_q.is_dm) begin
            dm_ready_d = 1'b1;
            dm_rdata_d = al_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      fair_q      <= '0;
      wait_q      <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      fair_q      <= fair_d;
      wait_q      <= wait_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      dm_err_q    <= dm_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign dm_err    = dm_err_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-latency memory model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2, FAIR_MAX = 4, AW = 14;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic          clk = 1'b0, rst;
  logic          if_req, if_ready, dm_req, dm_ready, dm_err, mem_en;
  logic [31:0]   if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic [2:0]    dm_ldst;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0, n_bad = 0, coincide = 0;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .FAIR_MAX(FAIR_MAX), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_ldst(dm_ldst), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: byte-write, two-stage read pipeline, poison when not enabled.
  logic [31:0] mem [0:1023];
  logic [31:0] rd0, rd1;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx;
  logic [31:0] bd_dat;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_dat;
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr[9:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      rd0 <= mem[mem_addr[9:0]];
    end else begin
      rd0 <= 32'hDEAD_BEEF;
    end
    rd1 <= rd0;
  end
  assign mem_rdata = rd1;

  always @(negedge clk) if (if_ready && dm_ready) coincide++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] d);
    bd_we = 1'b1; bd_idx = idx; bd_dat = d;
    tick;
    bd_we = 1'b0;
  endtask

  int          r_lat, r_en_cyc, r_en_n, r_other;
  logic [3:0]  r_we;
  logic [31:0] r_wd, r_rd;
  logic [AW-1:0] r_ma;
  logic        r_err;

  // Drives one request from an IDLE cycle (cycle 0) and records what the port did.
  task automatic access(input logic is_if, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd);
    r_lat = -1; r_en_cyc = -1; r_en_n = 0; r_other = 0;
    r_we = '0; r_wd = '0; r_ma = '0; r_rd = '0; r_err = 1'b0;
    if (is_if) begin if_req = 1'b1; if_addr = a; end
    else begin dm_req = 1'b1; dm_addr = a; dm_ldst = op; dm_wdata = wd; end
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (mem_en) begin r_en_n++; r_en_cyc = c; r_we = mem_we; r_wd = mem_wdata; r_ma = mem_addr; end
      if (is_if ? dm_ready : if_ready) r_other++;
      if (is_if ? if_ready : dm_ready) begin
        r_lat = c; r_rd = is_if ? if_rdata : dm_rdata; r_err = dm_err;
        break;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h40; dm_addr = 32'h80;
    dm_ldst = LW; dm_wdata = 32'h0;
    tick; tick;
    n_cmp++; if ({if_ready, dm_ready, dm_err, mem_en, mem_we} !== 8'h00) begin n_bad++;
      $display("FAIL reset_ctrl got %b want 00000000", {if_ready, dm_ready, dm_err, mem_en, mem_we}); end
    n_cmp++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin n_bad++;
      $display("FAIL reset_data got %h/%h/%h/%h want 0", mem_addr, mem_wdata, if_rdata, dm_rdata); end
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    tick;
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_no_req got %b want 0", mem_en); end
  endtask

  task automatic test_lw;
    poke(10'h040, 32'h8899_AABB);
    access(1'b0, LW, 32'h100, 32'h0);
    n_cmp++; if (r_en_cyc !== 1) begin n_bad++; $display("FAIL lw_en_cycle got %0d want 1", r_en_cyc); end
    n_cmp++; if (r_ma !== 14'h40) begin n_bad++; $display("FAIL lw_mem_addr got %h want 40", r_ma); end
    n_cmp++; if (r_we !== 4'b0000) begin n_bad++; $display("FAIL lw_we got %b want 0000", r_we); end
    n_cmp++; if (r_lat !== 4) begin n_bad++; $display("FAIL lw_latency got %0d want 4", r_lat); end
    n_cmp++; if (r_rd !== 32'h8899_AABB) begin n_bad++; $display("FAIL lw_rdata got %h want 8899aabb", r_rd); end
    n_cmp++; if (r_err !== 1'b0 || r_other !== 0) begin n_bad++; $display("FAIL lw_err_other got %b/%0d want 0/0", r_err, r_other); end
  endtask

  task automatic test_byte;
    poke(10'h080, 32'h1122_3344);
    access(1'b0, SB, 32'h203, 32'h0000_00C5);
    n_cmp++; if (r_we !== 4'b1000) begin n_bad++; $display("FAIL sb_we got %b want 1000", r_we); end
    n_cmp++; if (r_wd !== 32'hC5C5_C5C5) begin n_bad++; $display("FAIL sb_wdata got %h want c5c5c5c5", r_wd); end
    n_cmp++; if (r_lat !== 2 || r_en_cyc !== 1) begin n_bad++; $display("FAIL sb_timing got %0d/%0d want 2/1", r_lat, r_en_cyc); end
    n_cmp++; if (r_ma !== 14'h80) begin n_bad++; $display("FAIL sb_mem_addr got %h want 80", r_ma); end
    access(1'b0, LB, 32'h203, 32'h0);
    n_cmp++; if (r_rd !== 32'hFFFF_FFC5) begin n_bad++; $display("FAIL lb_sext got %h want ffffffc5", r_rd); end
    access(1'b0, LBU, 32'h203, 32'h0);
    n_cmp++; if (r_rd !== 32'h0000_00C5) begin n_bad++; $display("FAIL lbu_zext got %h want 000000c5", r_rd); end
    access(1'b0, LW, 32'h200, 32'h0);
    n_cmp++; if (r_rd !== 32'hC522_3344) begin n_bad++; $display("FAIL sb_lanes got %h want c5223344", r_rd); end
    access(1'b0, LB, 32'h200, 32'h0);
    n_cmp++; if (r_rd !== 32'h0000_0044) begin n_bad++; $display("FAIL lb_pos got %h want 00000044", r_rd); end
    access(1'b0, LBU, 32'h201, 32'h0);
    n_cmp++; if (r_rd !== 32'h0000_0033) begin n_bad++; $display("FAIL lbu_lane1 got %h want 00000033", r_rd); end
  endtask

  task automatic test_half;
    poke(10'h040, 32'h8001_7FFF);
    access(1'b0, LH, 32'h102, 32'h0);
    n_cmp++; if (r_rd !== 32'hFFFF_8001 || r_lat !== 4) begin n_bad++; $display("FAIL lh_hi got %h lat %0d want ffff8001 lat 4", r_rd, r_lat); end
    access(1'b0, LHU, 32'h102, 32'h0);
    n_cmp++; if (r_rd !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_hi got %h want 00008001", r_rd); end
    access(1'b0, LH, 32'h100, 32'h0);
    n_cmp++; if (r_rd !== 32'h0000_7FFF) begin n_bad++; $display("FAIL lh_lo got %h want 00007fff", r_rd); end
    access(1'b0, SH, 32'h101, 32'h0000_BEEF);
    n_cmp++; if (r_lat !== 1 || r_err !== 1'b1) begin n_bad++; $display("FAIL sh_misalign got lat %0d err %b want 1/1", r_lat, r_err); end
    n_cmp++; if (r_en_n !== 0 || r_rd !== 32'h0) begin n_bad++; $display("FAIL sh_misalign_quiet got en %0d rd %h want 0/0", r_en_n, r_rd); end
    access(1'b0, LW, 32'h100, 32'h0);
    n_cmp++; if (r_rd !== 32'h8001_7FFF) begin n_bad++; $display("FAIL mem_untouched got %h want 80017fff", r_rd); end
    access(1'b0, SH, 32'h102, 32'h0000_1234);
    n_cmp++; if (r_we !== 4'b1100 || r_wd !== 32'h1234_1234 || r_err !== 1'b0) begin n_bad++;
      $display("FAIL sh_hi got we %b wd %h err %b want 1100 12341234 0", r_we, r_wd, r_err); end
    access(1'b0, LW, 32'h100, 32'h0);
    n_cmp++; if (r_rd !== 32'h1234_7FFF) begin n_bad++; $display("FAIL sh_merge got %h want 12347fff", r_rd); end
    access(1'b0, LW, 32'h102, 32'h0);
    n_cmp++; if (r_err !== 1'b1 || r_lat !== 1 || r_en_n !== 0) begin n_bad++;
      $display("FAIL lw_misalign got err %b lat %0d en %0d want 1/1/0", r_err, r_lat, r_en_n); end
    access(1'b0, SW, 32'h104, 32'hCAFE_F00D);
    n_cmp++; if (r_we !== 4'b1111 || r_wd !== 32'hCAFE_F00D || r_ma !== 14'h41) begin n_bad++;
      $display("FAIL sw got we %b wd %h ma %h want 1111 cafef00d 41", r_we, r_wd, r_ma); end
    access(1'b0, LHU, 32'h106, 32'h0);
    n_cmp++; if (r_rd !== 32'h0000_CAFE) begin n_bad++; $display("FAIL lhu_after_sw got %h want 0000cafe", r_rd); end
  endtask

  task automatic test_fetch;
    poke(10'h001, 32'h1357_9BDF);
    access(1'b1, LW, 32'h0000_0007, 32'h0);
    n_cmp++; if (r_ma !== 14'h1 || r_we !== 4'b0000) begin n_bad++; $display("FAIL fetch_addr got ma %h we %b want 1/0000", r_ma, r_we); end
    n_cmp++; if (r_lat !== 4) begin n_bad++; $display("FAIL fetch_latency got %0d want 4", r_lat); end
    n_cmp++; if (r_rd !== 32'h1357_9BDF) begin n_bad++; $display("FAIL fetch_rdata got %h want 13579bdf", r_rd); end
    n_cmp++; if (r_other !== 0) begin n_bad++; $display("FAIL fetch_no_dm_ready got %0d want 0", r_other); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] seq;
    int n, bad_data;
    seq = '0; n = 0; bad_data = 0;
    poke(10'h010, 32'hA5A5_0001);
    poke(10'h020, 32'h0F0F_0002);
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_addr = 32'h40; dm_ldst = LW; dm_wdata = 32'h0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      tick;
      if (if_ready || dm_ready) begin
        seq[n] = if_ready;
        if (if_ready && if_rdata !== 32'h0F0F_0002) bad_data++;
        if (!if_ready && dm_rdata !== 32'hA5A5_0001) bad_data++;
        n++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick;
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_count got %0d want 10", n); end
    n_cmp++; if (seq !== 10'b10_0001_0000) begin n_bad++; $display("FAIL b2b_grant_seq got %b want 1000010000", seq); end
    n_cmp++; if (bad_data !== 0) begin n_bad++; $display("FAIL b2b_rdata got %0d bad want 0", bad_data); end
    n_cmp++; if (coincide !== 0) begin n_bad++; $display("FAIL ready_coincident got %0d want 0", coincide); end
  endtask

  task automatic test_reset_mid;
    int stale;
    stale = 0;
    poke(10'h002, 32'h2468_ACE0);
    poke(10'h003, 32'h7777_1111);
    if_req = 1'b1; if_addr = 32'h8;
    tick; tick;
    rst = 1'b1; if_req = 1'b0;
    tick;
    n_cmp++; if ({if_ready, dm_ready, dm_err, mem_en, mem_we} !== 8'h00) begin n_bad++;
      $display("FAIL midrst_ctrl got %b want 00000000", {if_ready, dm_ready, dm_err, mem_en, mem_we}); end
    n_cmp++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin n_bad++;
      $display("FAIL midrst_data got %h/%h/%h/%h want 0", mem_addr, mem_wdata, if_rdata, dm_rdata); end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (if_ready || dm_ready || mem_en) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL midrst_stale got %0d events want 0", stale); end
    access(1'b1, LW, 32'h0000_000C, 32'h0);
    n_cmp++; if (r_lat !== 4 || r_rd !== 32'h7777_1111) begin n_bad++;
      $display("FAIL midrst_refetch got lat %0d rd %h want 4 77771111", r_lat, r_rd); end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; if_addr = '0; dm_addr = '0;
    dm_ldst = LW; dm_wdata = '0; bd_idx = '0; bd_dat = '0;
    test_reset;
    test_lw;
    test_byte;
    test_half;
    test_fetch;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
